// File: rtl/data_sram_bridge.sv
// data_sram_bridge: connects the M-stage load/store port to an sram-like
// data master. It holds at most one transaction in flight and asks the
// hazard unit to stall the pipeline until the load data comes back.
// Optional build macro: DATA_BRIDGE_KSEG_MAP_EN. When it is defined,
// kseg0/kseg1 addresses (addr[31:30] == 2'b10) map to physical addresses
// by clearing addr[31:29].
module data_sram_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic [3:0]  mem_wen,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        flush_ex,
    input  logic        longest_stall,
    output logic [31:0] mem_rdata,
    output logic        stall_mem,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

    state_t      state_q, state_d;
    logic        req_wr_q, req_wr_d;
    logic [1:0]  req_size_q, req_size_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [31:0] rdata_buf_q, rdata_buf_d;

    logic        start;
    logic        in_wr;
    logic [1:0]  in_size;
    logic [31:0] in_addr;

    // Virtual-to-physical mapping applied to the address taken at issue
    function automatic logic [31:0] map_addr(input logic [31:0] a);
`ifdef DATA_BRIDGE_KSEG_MAP_EN
        map_addr = (a[31:30] == 2'b10) ? {3'b000, a[28:0]} : a;
`else
        map_addr = a;
`endif
    endfunction

    // Issue qualification and request fields taken straight from the pipeline.
    // Gating start with rst keeps data_req and stall_mem low while in reset.
    always_comb begin
        start   = (state_q == IDLE) & mem_en & ~flush_ex & ~rst;
        in_wr   = |mem_wen;
        in_size = (mem_size == 2'd3) ? 2'd2 : mem_size;
        in_addr = map_addr(mem_addr);
    end

    // Next-state logic and capture of the request and the returned load data
    always_comb begin
        state_d     = state_q;
        req_wr_d    = req_wr_q;
        req_size_d  = req_size_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        rdata_buf_d = rdata_buf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    req_wr_d    = in_wr;
                    req_size_d  = in_size;
                    req_addr_d  = in_addr;
                    req_wdata_d = mem_wdata;
                    state_d     = data_addr_ok ? DATA : ADDR;
                end
            end
            // A data_ok seen here cannot belong to this request, so it is ignored
            ADDR: begin
                if (data_addr_ok) state_d = DATA;
            end
            DATA: begin
                if (data_data_ok) begin
                    rdata_buf_d = data_rdata;
                    state_d     = longest_stall ? HOLD : IDLE;
                end
            end
            // Pipeline is frozen by another source; keep the load data until it moves
            HOLD: begin
                if (!longest_stall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and capture registers; reset can abort a transaction at any point
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_wr_q    <= 1'b0;
            req_size_q  <= 2'd0;
            req_addr_q  <= 32'd0;
            req_wdata_q <= 32'd0;
            rdata_buf_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            req_wr_q    <= req_wr_d;
            req_size_q  <= req_size_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            rdata_buf_q <= rdata_buf_d;
        end
    end

    // Master request: live fields on the issue cycle, captured fields while
    // waiting for addr_ok so they stay stable whatever the pipeline does
    always_comb begin
        data_req = start | (state_q == ADDR);
        if (state_q == IDLE) begin
            data_wr    = in_wr;
            data_size  = in_size;
            data_addr  = in_addr;
            data_wdata = mem_wdata;
        end else begin
            data_wr    = req_wr_q;
            data_size  = req_size_q;
            data_addr  = req_addr_q;
            data_wdata = req_wdata_q;
        end
    end

    // Pipeline side: stall until data_ok, forward the data in that same cycle
    always_comb begin
        stall_mem = start | (state_q == ADDR) | ((state_q == DATA) & ~data_data_ok);
        mem_rdata = ((state_q == DATA) & data_data_ok) ? data_rdata : rdata_buf_q;
    end

endmodule
